// File: rtl/router_pkt_tx.sv
// router_pkt_tx: source end of the 1x3 router packet protocol.
// Takes a command (addr, len) and buffers len payload bytes. It then sends
// the header, the payload and the parity byte under router busy
// back-pressure, and finally samples router err for ERR_WAIT clocks.
// Build option: `define PARITY_CORRUPT_EN adds input `corrupt`, latched with
// the command; when it is set, the sent parity byte has bit 0 flipped.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// offering side keeps valid and data stable until that edge, and ready never
// depends combinationally on valid.
module router_pkt_tx #(
  parameter int MAX_LEN  = 63,
  parameter int ERR_WAIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
`ifdef PARITY_CORRUPT_EN
  input  logic       corrupt,
`endif
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  input  logic       busy,
  input  logic       err,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       done,
  output logic       done_err,
  output logic       cmd_rej,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PARITY  = 3'd4,
    S_ERR_CHK = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);
  localparam logic [3:0] WAIT_LAST = 4'(ERR_WAIT - 1);

  state_t     state, state_nxt;
  logic [7:0] mem [MAX_LEN];
  logic [7:0] header_q, parity_q, parity_tx;
  logic [5:0] len_q, wptr, rptr, rptr_nxt;
  logic [3:0] wait_cnt;
  logic       sticky;
  logic       cmd_fire, cmd_bad, accept, pl_fire, last_load, last_pay, wait_last;
  logic       cmd_ready_d, pl_ready_d, pkt_valid_d, done_d, done_err_d, cmd_rej_d;
  logic [7:0] data_d;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign cmd_bad   = (cmd_addr == 2'd3) || (cmd_len == 6'd0) || ({1'b0, cmd_len} > MAX_LEN_W);
  assign accept    = (state == S_IDLE) && cmd_fire && !cmd_bad;
  assign pl_fire   = pl_valid && pl_ready;
  assign last_load = pl_fire && (wptr == len_q - 6'd1);
  assign last_pay  = (rptr == len_q - 6'd1);
  assign wait_last = (wait_cnt == WAIT_LAST);
  assign rptr_nxt  = ((state == S_PAYLOAD) && !busy) ? rptr + 6'd1 : rptr;
  assign fsm_state = state;

`ifdef PARITY_CORRUPT_EN
  logic corrupt_q;

  // Latch the corrupt request together with the command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         corrupt_q <= 1'b0;
    else if (accept) corrupt_q <= corrupt;
  end

  assign parity_tx = parity_q ^ {7'd0, corrupt_q};
`else
  assign parity_tx = parity_q;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; every byte on the router side waits for busy==0.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept)               state_nxt = S_LOAD;
      S_LOAD:    if (last_load)            state_nxt = S_HEADER;
      S_HEADER:  if (!busy)                state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (!busy && last_pay)    state_nxt = S_PARITY;
      S_PARITY:  if (!busy)                state_nxt = S_ERR_CHK;
      S_ERR_CHK: if (wait_last)            state_nxt = S_DONE;
      S_DONE:                              state_nxt = S_IDLE;
      default:                             state_nxt = S_IDLE;
    endcase
  end

  // Output logic computed from the next state so the registered outputs line up with the state register.
  always_comb begin
    cmd_ready_d = (state_nxt == S_IDLE);
    pl_ready_d  = (state_nxt == S_LOAD);
    pkt_valid_d = (state_nxt == S_HEADER) || (state_nxt == S_PAYLOAD);
    done_d      = (state_nxt == S_DONE);
    done_err_d  = (state_nxt == S_DONE) && (sticky || err);
    cmd_rej_d   = (state == S_IDLE) && cmd_fire && cmd_bad;
    data_d      = 8'h00;
    case (state_nxt)
      S_HEADER:  data_d = header_q;
      S_PAYLOAD: data_d = mem[rptr_nxt];
      S_PARITY:  data_d = parity_tx;
      default:   data_d = 8'h00;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b0;
      pl_ready  <= 1'b0;
      pkt_valid <= 1'b0;
      data_out  <= 8'h00;
      done      <= 1'b0;
      done_err  <= 1'b0;
      cmd_rej   <= 1'b0;
    end else begin
      cmd_ready <= cmd_ready_d;
      pl_ready  <= pl_ready_d;
      pkt_valid <= pkt_valid_d;
      data_out  <= data_d;
      done      <= done_d;
      done_err  <= done_err_d;
      cmd_rej   <= cmd_rej_d;
    end
  end

  // Datapath: header/parity capture, buffer pointers, err window counter and sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      header_q <= 8'h00;
      len_q    <= 6'd0;
      parity_q <= 8'h00;
      wptr     <= 6'd0;
      rptr     <= 6'd0;
      wait_cnt <= 4'd0;
      sticky   <= 1'b0;
    end else begin
      rptr <= rptr_nxt;
      if (accept) begin
        header_q <= {cmd_len, cmd_addr};
        len_q    <= cmd_len;
        parity_q <= {cmd_len, cmd_addr};
        wptr     <= 6'd0;
        rptr     <= 6'd0;
        wait_cnt <= 4'd0;
        sticky   <= 1'b0;
      end
      if ((state == S_LOAD) && pl_fire) begin
        wptr     <= wptr + 6'd1;
        parity_q <= parity_q ^ pl_data;
      end
      if (state == S_ERR_CHK) begin
        sticky   <= sticky | err;
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  // Payload buffer write port.
  always_ff @(posedge clk) begin
    if ((state == S_LOAD) && pl_fire) mem[wptr] <= pl_data;
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: scoreboard bench for router_pkt_tx.
// The drivers push the expected router-side bytes and the expected per-command
// status into queues. A negedge monitor pops an entry and compares it whenever
// a byte transfers (busy==0) or a done/cmd_rej pulse appears.
`timescale 1ns/1ps
module tb_router_pkt_tx;
  localparam int MAX_LEN  = 63;
  localparam int ERR_WAIT = 3;
  localparam int CLK_HALF = 5;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_addr = 2'd0;
  logic [5:0] cmd_len = 6'd0;
  logic       pl_valid = 1'b0;
  logic       pl_ready;
  logic [7:0] pl_data = 8'h00;
  logic       busy = 1'b0;
  logic       err = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       done, done_err, cmd_rej;
  logic [2:0] fsm_state;
`ifdef PARITY_CORRUPT_EN
  logic       corrupt = 1'b0;
`endif

  always #CLK_HALF clk = ~clk;

  router_pkt_tx #(.MAX_LEN(MAX_LEN), .ERR_WAIT(ERR_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
`ifdef PARITY_CORRUPT_EN
    .corrupt(corrupt),
`endif
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .busy(busy), .err(err),
    .pkt_valid(pkt_valid), .data_out(data_out),
    .done(done), .done_err(done_err), .cmd_rej(cmd_rej),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] exp_q[$];   // {pkt_valid, byte} per router-side transfer
  logic [1:0] stat_q[$];  // 2'b00 ok, 2'b01 done with err, 2'b10 rejected
  logic [7:0] pay [64];
  bit         busy_rand = 1'b0;
  bit         busy_force = 1'b0;
  bit         in_pkt = 1'b0;
  bit         par_seen = 1'b0;
  int         tx_cnt = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference model: expected bytes and status straight from the packet rules.
  task automatic push_exp(input logic [1:0] a, input logic [5:0] l, input bit e, input bit cor);
    logic [7:0] h, p;
    if (a == 2'd3 || l == 6'd0 || int'(l) > MAX_LEN) begin
      stat_q.push_back(2'b10);
      return;
    end
    h = {l, a};
    p = h;
    exp_q.push_back({1'b1, h});
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back({1'b1, pay[i]});
      p = p ^ pay[i];
    end
    if (cor) p = p ^ 8'h01;
    exp_q.push_back({1'b0, p});
    stat_q.push_back({1'b0, e});
  endtask

  // ---------------- busy driver ----------------
  always @(posedge clk) begin
    #1;
    if (busy_rand) busy = ($urandom_range(0, 3) == 0);
    else           busy = busy_force;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [8:0] got, e9;
    logic [1:0] st, e2;
    if (rst) begin
      in_pkt = 1'b0;
    end else begin
      if (!busy && (pkt_valid || in_pkt)) begin
        got = {pkt_valid, data_out};
        tx_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_byte: actual=%h required=none (t=%0t)", got, $time);
        end else begin
          e9 = exp_q.pop_front();
          check("tx_byte", 16'(got), 16'(e9));
        end
        if (!pkt_valid) par_seen = 1'b1;
        in_pkt = pkt_valid;
      end
      if (done || cmd_rej) begin
        st = cmd_rej ? 2'b10 : {1'b0, done_err};
        if (stat_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL status: actual=%b required=none (t=%0t)", st, $time);
        end else begin
          e2 = stat_q.pop_front();
          check("status", 16'(st), 16'(e2));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_cmd(input logic [1:0] a, input logic [5:0] l);
    bit got = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    for (int b = 0; b < 200; b++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; break; end
    end
    if (!got) fail_now("cmd_handshake");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // gap: 0 always valid, 1 toggle every other cycle, 2 random.
  task automatic do_load(input int l, input int gap, input bit rand_err);
    int i = 0;
    int b = 0;
    bit tog = 1'b0;
    while (i < l && b < 1000) begin
      tog = ~tog;
      case (gap)
        0:       pl_valid = 1'b1;
        1:       pl_valid = tog;
        default: pl_valid = ($urandom_range(0, 1) == 1);
      endcase
      pl_data = pay[i];
      if (rand_err) err = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (pl_valid && pl_ready) i++;
      b++;
      @(posedge clk); #1;
    end
    pl_valid = 1'b0;
    err = 1'b0;
    if (i < l) fail_now("payload_load");
  endtask

  // Header is held while busy is forced high for two edges.
  task automatic hdr_hold(input logic [7:0] h);
    bit ok = 1'b0;
    int snap;
    for (int b = 0; b < 100; b++) begin
      @(negedge clk);
      if (pkt_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("hdr_wait");
    snap = tx_cnt;
    check("hdr_first", 16'(data_out), 16'(h));
    @(posedge clk);
    @(negedge clk);
    check("hdr_held", 16'({pkt_valid, data_out}), 16'({1'b1, h}));
    check("hdr_no_early_tx", 16'(tx_cnt), 16'(snap));
    @(posedge clk);
    busy_force = 1'b0;
  endtask

  task automatic pulse_err_in_chk();
    bit ok = 1'b0;
    for (int b = 0; b < 3000; b++) begin
      @(negedge clk);
      if (par_seen) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("parity_wait");
    @(posedge clk); #1;
    err = 1'b1;
    @(posedge clk); #1;
    err = 1'b0;
  endtask

  task automatic wait_status();
    bit ok = 1'b0;
    for (int b = 0; b < 3000; b++) begin
      @(negedge clk);
      if (stat_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("status_wait");
  endtask

  task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input int gap,
                         input bit hold, input bit errchk, input bit cor, input bit rand_err);
    bit legal;
    legal = (a != 2'd3) && (l != 6'd0) && (int'(l) <= MAX_LEN);
    par_seen = 1'b0;
    push_exp(a, l, errchk, cor);
    do_cmd(a, l);
    if (legal) begin
      do_load(int'(l), gap, rand_err);
      if (hold) hdr_hold({l, a});
      if (errchk) pulse_err_in_chk();
    end else begin
      pl_valid = 1'b1;
      pl_data  = 8'h5A;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("rej_pl_ready", 16'(pl_ready), 16'(0));
        check("rej_pkt_valid", 16'(pkt_valid), 16'(0));
      end
      pl_valid = 1'b0;
    end
    wait_status();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(CLK_HALF * 2 * 60000);
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int base;
    bit ok;
    logic [1:0] ra;
    logic [5:0] rl;

    // Reset state.
    #3;
    check("reset_outputs", 16'({pkt_valid, data_out, cmd_ready, pl_ready, done, done_err, cmd_rej}), 16'(0));
    repeat (2) @(negedge clk);
    check("reset_outputs_held", 16'({pkt_valid, data_out, cmd_ready, pl_ready, done, done_err, cmd_rej}), 16'(0));
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", 16'(cmd_ready), 16'(1));

    // Basic packet, no back-pressure.
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    run_pkt(2'd1, 6'd3, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Same packet with busy held for two edges on the header.
    busy_force = 1'b1;
    run_pkt(2'd1, 6'd3, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Illegal commands.
    run_pkt(2'd3, 6'd5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_pkt(2'd0, 6'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Maximum length, toggling pl_valid.
    for (int i = 0; i < 63; i++) pay[i] = 8'(i);
    run_pkt(2'd2, 6'd63, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Router err inside the check window.
    pay[0] = 8'h3C; pay[1] = 8'h99;
    run_pkt(2'd0, 6'd2, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized packets with random busy, pl_valid gaps and err outside the window.
    busy_rand = 1'b1;
    for (int k = 0; k < 24; k++) begin
      ra = 2'($urandom_range(0, 3));
      rl = 6'($urandom_range(0, 12));
      for (int i = 0; i < int'(rl); i++) pay[i] = 8'($urandom_range(0, 255));
      run_pkt(ra, rl, 2, 1'b0, ($urandom_range(0, 3) == 0), 1'b0, 1'b1);
    end
    busy_rand = 1'b0;
    busy_force = 1'b0;

    // Reset in the middle of the payload drops the packet.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    par_seen = 1'b0;
    push_exp(2'd1, 6'd4, 1'b0, 1'b0);
    base = tx_cnt;
    do_cmd(2'd1, 6'd4);
    do_load(4, 0, 1'b0);
    ok = 1'b0;
    for (int b = 0; b < 100; b++) begin
      @(negedge clk);
      if (tx_cnt >= base + 2) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("rst_mid_wait");
    check("pre_rst_pkt_valid", 16'(pkt_valid), 16'(1));
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_outputs", 16'({pkt_valid, data_out, done, cmd_ready, pl_ready}), 16'(0));
    exp_q.delete();
    stat_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_idle", 16'({cmd_ready, pkt_valid, done}), 16'(3'b100));

    pay[0] = 8'h55;
    run_pkt(2'd0, 6'd1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef PARITY_CORRUPT_EN
    // Corrupted parity with router err in the window.
    corrupt = 1'b1;
    pay[0] = 8'h55;
    run_pkt(2'd0, 6'd1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    corrupt = 1'b0;
`endif

    repeat (4) @(negedge clk);
    check("exp_q_drained", 16'(exp_q.size()), 16'(0));
    check("stat_q_drained", 16'(stat_q.size()), 16'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
